// File: rtl/stoch_mean_mc_if.sv
// Bus bundle for stoch_mean_mc: window control, stochastic inputs, and latched counts.
// master = stimulus side (drives control/in), slave = estimator (drives out/out_valid/busy).
interface stoch_mean_mc_if #(
    parameter int N_CH    = 4,
    parameter int N_COUNT = 8
);
    logic                    ENABLE;
    logic                    START_WIN;
    logic [N_COUNT-1:0]      WIN_LEN;
    logic                    MODE;
    logic [N_CH-1:0]         in;
    logic [N_CH*N_COUNT-1:0] out;
    logic                    out_valid;
    logic                    busy;

    modport master (
        output ENABLE, START_WIN, WIN_LEN, MODE, in,
        input  out, out_valid, busy
    );

    modport slave (
        input  ENABLE, START_WIN, WIN_LEN, MODE, in,
        output out, out_valid, busy
    );
endinterface

// File: rtl/stoch_mean_mc.sv
// Multi-channel windowed 1s counter for stochastic bitstreams (single-shot or continuous).
// Ports: CLK, RESET (async high); bus.slave carries ENABLE/START_WIN/WIN_LEN/MODE/in -> out/out_valid/busy.
module stoch_mean_mc #(
    parameter int               N_CH     = 4,
    parameter int               N_COUNT  = 8,
    parameter logic [N_COUNT-1:0] INIT_OUT = '0
) (
    input  logic           CLK,
    input  logic           RESET,
    stoch_mean_mc_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                          state_q, state_d;
    logic [N_COUNT-1:0]              cnt_q, cnt_d;
    logic [N_COUNT-1:0]              w_lat_q, w_lat_d;
    logic [N_CH-1:0][N_COUNT-1:0]    sum_q, sum_d;
    logic [N_CH-1:0][N_COUNT-1:0]    out_q, out_d;
    logic                            valid_q, valid_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_lat_q <= '0;
            sum_q   <= '0;
            out_q   <= {N_CH{INIT_OUT}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_lat_q <= w_lat_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_lat_d = w_lat_q;
        sum_d   = sum_q;
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.START_WIN && bus.WIN_LEN != '0) begin
                    w_lat_d = bus.WIN_LEN;
                    cnt_d   = bus.WIN_LEN;
                    sum_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // A start request overrides any sample, including a last one.
                if (bus.START_WIN) begin
                    sum_d   = '0;
                    cnt_d   = bus.WIN_LEN;
                    w_lat_d = bus.WIN_LEN;
                    if (bus.WIN_LEN == '0) begin
                        state_d = IDLE;
                    end
                end else if (bus.ENABLE) begin
                    for (int i = 0; i < N_CH; i++) begin
                        sum_d[i] = sum_q[i] + N_COUNT'(bus.in[i]);
                    end
                    if (cnt_q == N_COUNT'(1)) begin
                        // Final sample is folded into the published count.
                        out_d   = sum_d;
                        sum_d   = '0;
                        valid_d = 1'b1;
                        if (bus.MODE) begin
                            cnt_d = w_lat_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - N_COUNT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q == ACCUM);
endmodule

// File: tb/tb_stoch_mean_mc.sv
// Self-checking bench for stoch_mean_mc: vector table, directed corner sequences,
// and randomized traffic against a count-based reference model.
module tb_stoch_mean_mc;
    localparam int NC = 4;
    localparam int NW = 8;

    logic CLK;
    logic RESET;

    stoch_mean_mc_if #(.N_CH(NC), .N_COUNT(NW)) bus ();

    stoch_mean_mc #(
        .N_CH(NC), .N_COUNT(NW), .INIT_OUT(8'h2A)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    string phase = "init";

    // Reference model: a window is "W enabled samples"; count ones taken so far.
    bit          m_busy;
    int          m_w;
    int          m_taken;
    int          m_acc [NC];
    logic [31:0] m_out;
    bit          m_valid;

    typedef struct {
        logic       en;
        logic       st;
        logic [7:0] wl;
        logic       md;
        logic [3:0] iv;
        logic [31:0] e_out;
        logic       e_valid;
        logic       e_busy;
    } vec_t;

    vec_t vecs [12];

    task automatic model_reset();
        m_busy  = 0;
        m_w     = 0;
        m_taken = 0;
        foreach (m_acc[i]) m_acc[i] = 0;
        m_out   = 32'h2A2A2A2A;
        m_valid = 0;
    endtask

    task automatic model_edge(input logic en, st, input logic [7:0] wl,
                              input logic md, input logic [3:0] iv);
        m_valid = 0;
        if (st && (m_busy || wl != 0)) begin
            m_busy  = (wl != 0);
            m_w     = int'(wl);
            m_taken = 0;
            foreach (m_acc[i]) m_acc[i] = 0;
        end else if (m_busy && en) begin
            for (int i = 0; i < NC; i++) m_acc[i] += int'(iv[i]);
            m_taken++;
            if (m_taken == m_w) begin
                for (int i = 0; i < NC; i++) m_out[i*8 +: 8] = 8'(m_acc[i]);
                m_valid = 1;
                m_taken = 0;
                foreach (m_acc[i]) m_acc[i] = 0;
                if (!md) m_busy = 0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h at %0t", phase, nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, st, input logic [7:0] wl,
                        input logic md, input logic [3:0] iv);
        bus.ENABLE    = en;
        bus.START_WIN = st;
        bus.WIN_LEN   = wl;
        bus.MODE      = md;
        bus.in        = iv;
        @(posedge CLK);
        model_edge(en, st, wl, md, iv);
        #1;
        if (bus.out_valid) pulses++;
        check("out", bus.out, m_out);
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #2;
        model_reset();
        check("rst_out", bus.out, 32'h2A2A2A2A);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        int guard;
        int ones;
        RESET         = 1'b1;
        bus.ENABLE    = 1'b0;
        bus.START_WIN = 1'b0;
        bus.WIN_LEN   = '0;
        bus.MODE      = 1'b0;
        bus.in        = '0;

        vecs[0]  = '{1'b0, 1'b1, 8'd3, 1'b0, 4'b0000, 32'h2A2A2A2A, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'd0, 1'b0, 4'b0101, 32'h2A2A2A2A, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 4'b1111, 32'h2A2A2A2A, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 8'd0, 1'b0, 4'b0011, 32'h2A2A2A2A, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 8'd0, 1'b0, 4'b1001, 32'h01010103, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'd0, 1'b0, 4'b1111, 32'h01010103, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'd0, 1'b0, 4'b1111, 32'h01010103, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'd2, 1'b1, 4'b0000, 32'h01010103, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'd0, 1'b1, 4'b0001, 32'h01010103, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 8'd0, 1'b1, 4'b0001, 32'h00000002, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'd0, 1'b1, 4'b0010, 32'h00000002, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'd0, 1'b1, 4'b1111, 32'h00000002, 1'b0, 1'b0};

        #12;
        phase = "reset";
        do_reset();
        repeat (2) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b1111);
        check("held_out", bus.out, 32'h2A2A2A2A);

        phase = "table";
        for (int k = 0; k < 12; k++) begin
            step(vecs[k].en, vecs[k].st, vecs[k].wl, vecs[k].md, vecs[k].iv);
            check($sformatf("v%0d_out", k), bus.out, vecs[k].e_out);
            check($sformatf("v%0d_vld", k), 32'(bus.out_valid), 32'(vecs[k].e_valid));
            check($sformatf("v%0d_bsy", k), 32'(bus.busy), 32'(vecs[k].e_busy));
        end

        phase = "single";
        do_reset();
        pulses = 0;
        step(1'b1, 1'b1, 8'd16, 1'b0, 4'b0101);
        repeat (20) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b0101);
        check("ss_out", bus.out, 32'h00100010);
        check("ss_pulses", 32'(pulses), 32'd1);

        phase = "gated";
        ones = 0;
        step(1'b0, 1'b1, 8'd200, 1'b0, 4'b0000);
        guard = 0;
        while (m_busy && guard < 2000) begin
            logic e;
            logic [3:0] v;
            e = 1'($urandom_range(0, 1));
            v = 4'($urandom);
            v[0] = ($urandom_range(0, 3) == 0);
            if (e) ones += int'(v[0]);
            step(e, 1'b0, 8'd0, 1'b0, v);
            guard++;
        end
        check("gated_done", 32'(m_busy), 32'd0);
        check("gated_ch0", 32'(bus.out[7:0]), 32'(ones));

        phase = "cont";
        pulses = 0;
        step(1'b1, 1'b1, 8'd3, 1'b1, 4'b0001);
        repeat (9) step(1'b1, 1'b0, 8'd0, 1'b1, 4'b0001);
        check("cont_pulses", 32'(pulses), 32'd3);
        check("cont_ch0", bus.out, 32'h00000003);
        step(1'b1, 1'b0, 8'd0, 1'b0, 4'b0001);
        repeat (6) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b0001);
        check("cont_pulses2", 32'(pulses), 32'd4);
        check("cont_idle", 32'(bus.busy), 32'd0);

        phase = "restart";
        pulses = 0;
        step(1'b1, 1'b1, 8'd8, 1'b0, 4'b1111);
        repeat (4) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b1111);
        step(1'b1, 1'b1, 8'd8, 1'b0, 4'b1111);
        repeat (7) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b0011);
        step(1'b1, 1'b1, 8'd8, 1'b0, 4'b1111);
        check("coll_pulses", 32'(pulses), 32'd0);
        check("coll_out", bus.out, 32'h00000003);
        repeat (8) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b0110);
        check("restart_out", bus.out, 32'h00080800);
        step(1'b1, 1'b1, 8'd5, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 8'd0, 1'b0, 4'b0000);
        check("abort_idle", 32'(bus.busy), 32'd0);

        phase = "w255";
        step(1'b1, 1'b1, 8'd255, 1'b0, 4'b1111);
        repeat (255) step(1'b1, 1'b0, 8'd0, 1'b0, 4'b1111);
        check("w255_out", bus.out, 32'hFFFFFFFF);

        phase = "midrst";
        step(1'b1, 1'b1, 8'd10, 1'b1, 4'b1111);
        repeat (4) step(1'b1, 1'b0, 8'd0, 1'b1, 4'b1111);
        do_reset();
        step(1'b1, 1'b0, 8'd0, 1'b1, 4'b1111);

        phase = "random";
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0),
                 8'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stoch_mean_mc.md
Name: stoch_mean_mc

Overview:
Multi-channel windowed mean estimator for stochastic bitstreams. Per channel, it counts the 1s in a runtime-programmable window of W enabled clock cycles. At window end it latches each count into a held output and pulses a valid strobe. It sits after stochastic neuron/HHMM stages and feeds binary-domain logic. Single-shot and continuous back-to-back windowing are supported.

Parameters:
N_CH, 4, number of independent stochastic input channels
N_COUNT, 8, width of per-channel count, window length and output word
INIT_OUT, 0, value loaded into every output word on reset

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
ENABLE  input  1  sample qualifier; 0 freezes accumulation and window counter
START_WIN  input  1  single-cycle pulse that (re)starts a window
WIN_LEN  input  N_COUNT  window length W in enabled cycles; sampled only on START_WIN
MODE  input  1  0 = single-shot, 1 = continuous (auto-restart with latched W)
in  input  N_CH  one stochastic bit per channel; bit i is channel i
out  output  N_CH*N_COUNT  latched counts; channel i at [i*N_COUNT +: N_COUNT]
out_valid  output  1  one-cycle pulse: out was updated at this edge
busy  output  1  high while a window is in progress (state ACCUM)

Behaviour:
- Reset (async, RESET=1): state IDLE; sums=0; cnt=0; w_lat=0; every out word=INIT_OUT; out_valid=0; busy=0. Outputs hold these values until RESET deasserts and a window completes.
- Registers: sum[i] (N_COUNT bits each), cnt (N_COUNT), w_lat (N_COUNT), state {IDLE, ACCUM}.
- IDLE: START_WIN=1 with WIN_LEN!=0 -> w_lat<=WIN_LEN, cnt<=WIN_LEN, sums<=0, state ACCUM. START_WIN with WIN_LEN=0 is ignored; state stays IDLE. ENABLE is don't-care in IDLE.
- ACCUM, ENABLE=1, cnt>1: sum[i]<=sum[i]+in[i]; cnt<=cnt-1.
- ACCUM, ENABLE=1, cnt==1 (last sample): out word i<=sum[i]+in[i] (includes this cycle's bit); out_valid<=1 for exactly the next cycle; sums<=0. If MODE=1: cnt<=w_lat and stay in ACCUM, so windows run back-to-back with no dropped sample. If MODE=0: state IDLE.
- ACCUM, ENABLE=0: sums, cnt and out hold; out_valid=0.
- No overflow: W<=2^N_COUNT-1, so a sum never exceeds 2^N_COUNT-1. Plain N_COUNT-bit addition; no saturation logic.
- Latency: out is valid on the edge that consumes the W-th enabled sample. out_valid is asserted in the cycle after that edge.
- START_WIN in ACCUM (restart/abort): sums<=0, cnt<=WIN_LEN, w_lat<=WIN_LEN. The current sample is discarded, out is unchanged and out_valid stays 0. If WIN_LEN=0: go to IDLE.
- START_WIN in the same cycle as a last sample: START_WIN wins. No out update, no out_valid; the new window begins.
- MODE may change at any time. It is evaluated only at window end.
- out changes only at window completion or reset. Between completions it is stable.
- busy = (state==ACCUM), registered.
- RESET asserted mid-window: immediate return to the reset values above. The partial window is lost.

Test Plan:
- Reset: assert RESET with INIT_OUT=8'h2A, N_CH=4 -> out=0x2A2A2A2A, out_valid=0, busy=0. Outputs are held after deassert.
- Single-shot: MODE=0, WIN_LEN=16, START_WIN; in=4'b0101 constant, ENABLE=1 -> after 16 cycles ch0=ch2=16, ch1=ch3=0; one out_valid pulse; busy drops; no further updates.
- Stochastic mean with gating: WIN_LEN=200, ch0 Bernoulli p=0.25 (LFSR), ENABLE toggling 50% -> completes after 200 enabled cycles; ch0 equals the reference count of 1s on enabled cycles (~50).
- Continuous: MODE=1, WIN_LEN=3, in[0]=1 constant -> out_valid every 3 cycles, ch0=3 each time, no gap cycles. Switch MODE to 0 mid-window -> exactly one more pulse, then IDLE.
- Restart/collision: START_WIN (WIN_LEN=8) at cnt==4, then START_WIN coincident with a last sample -> out unchanged, no out_valid, new window of 8 completes correctly. WIN_LEN=0 start in ACCUM -> IDLE.
- Boundaries: WIN_LEN=255 with all-ones input -> out=255 per channel, no wrap. RESET pulse mid-window -> out returns to INIT_OUT, busy=0.
